seg7_sequence_decoder: RTL and testbench
========================================

Name: seg7_sequence_decoder

Overview:
- Receive side of the seconds-digit display bus: samples the seven active-low segment lines a..g, debounces them, and decodes them back to a BCD digit.
- Tracks the accepted digit sequence. Flags wraps (MAX_DIGIT -> 0) as a carry pulse and counts them; flags illegal patterns and out-of-order digits.
- Used as a display-path checker and as a digit/carry recovery block for the next counter stage.

Parameters:
- STABLE_CYCLES, 2, consecutive identical samples required before a pattern is accepted (legal range 1..15).
- MAX_DIGIT, 5, last digit before the expected wrap to 0 (legal range 1..9).

Ports:
- clock  input  1  system clock, all logic on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- a, b, c, d, e, f, g  input  1 each  segment lines, active-low (0 = segment lit).
- digit  output  4  last accepted legal digit.
- digit_valid  output  1  one-cycle pulse on each accepted legal digit.
- blank  output  1  level; 1 while the last accepted pattern is all-off.
- illegal  output  1  one-cycle pulse on an accepted undecodable pattern.
- wrap_pulse  output  1  one-cycle pulse on an accepted MAX_DIGIT -> 0 transition.
- seq_error  output  1  one-cycle pulse on an out-of-sequence accepted digit.
- wrap_count  output  8  number of wraps since reset, modulo 256.

Behaviour:
- Reset values: digit=0, digit_valid=0, blank=1, illegal=0, wrap_pulse=0, seq_error=0, wrap_count=0, state=S_EMPTY, stable counter=0, last-accepted pattern=7'b1111111.
- Reset is asynchronous. Asserting it mid-sequence drops all history; the first digit after release is never a seq_error.
- Input stage: {a..g} is registered every cycle into samp.
- Stable counter: cleared when samp differs from the previous samp. Otherwise it increments, saturating at STABLE_CYCLES.
- Accept event: the counter reaches STABLE_CYCLES and samp differs from the last-accepted pattern.
  - Fires exactly once per new pattern.
  - Latency: STABLE_CYCLES+1 cycles from the input change to the output pulse.
  - A pattern that returns to the last-accepted value never re-triggers.
- Decode table, abcdefg with 0 = lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 1111111 = blank.
  - Any other pattern is illegal.
- State machine: S_EMPTY (no reference digit), S_LOCKED (reference digit p held), S_ERROR (after an illegal pattern).
- On an accepted legal digit n:
  - digit<=n and digit_valid pulses.
  - From S_EMPTY or S_ERROR: no sequence check; go to S_LOCKED with p=n.
  - From S_LOCKED:
    - n==p+1 with n<=MAX_DIGIT: OK.
    - p==MAX_DIGIT and n==0: wrap_pulse and wrap_count+1, wrapping 255->0.
    - n==0 from any other p: counter-reset restart; no flags.
    - Anything else, including n>MAX_DIGIT: seq_error.
  - p<=n in every case.
  - blank<=0.
- On an accepted blank: blank<=1, go to S_EMPTY; digit holds.
- On an accepted illegal pattern: illegal pulses, go to S_ERROR; digit and blank hold.
- Pulses are mutually exclusive within a cycle, except digit_valid with wrap_pulse or seq_error.
- All outputs are registered. There is no combinational path from a..g.

Optional Feature:
- SEG7_HEX_DECODE_EN
- Defined: the additional patterns A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000 decode to 10..15. They are legal digits; because they exceed MAX_DIGIT, from S_LOCKED they raise seq_error.
- Undefined: those patterns are illegal.

Test Plan:
- Reset, then drive 0,1,2,3,4,5,0, each held 4 cycles (STABLE_CYCLES=2) -> digit_valid pulses 7 times, each 3 cycles after the change; wrap_pulse once on the final 0; wrap_count=1; seq_error never.
- Hold digit 3 steady, insert a 1-cycle glitch to 1111000, then return to 3 -> no pulses; digit stays 3.
- Sequence 2 then 4 -> seq_error on the 4; digit=4. Next 5 -> clean. Then 0 -> wrap_pulse.
- Drive 1111000 -> illegal pulse. Then drive 3 -> digit_valid, no seq_error. Then drive 4 -> clean.
- Sequence 4, then blank 1111111, then 2 -> blank=1 after the blank and 0 after the 2; no seq_error.
- Run 256 full 0..5 cycles -> wrap_count returns to 0. Assert RESET mid-digit -> all outputs at reset values immediately, before the next clock edge.
- With SEG7_HEX_DECODE_EN defined, drive 0001000 -> digit=10 with digit_valid; without it, illegal pulses instead.

Source files
------------

// File: rtl/seg7_sequence_decoder.sv
// Seconds-digit display receiver: samples active-low segments a..g, debounces, decodes to BCD and checks the digit sequence.
// Build option: define SEG7_HEX_DECODE_EN to decode the A..F patterns as digits 10..15 instead of treating them as illegal.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_EMPTY  | no reference digit (after reset or an accepted blank)
// S_LOCKED | reference digit held; the next accepted digit is sequence-checked
// S_ERROR  | last accepted pattern was illegal; the next digit is not checked

module seg7_sequence_decoder #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned MAX_DIGIT     = 5
) (
  input  logic       clock,
  input  logic       RESET,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       blank,
  output logic       illegal,
  output logic       wrap_pulse,
  output logic       seq_error,
  output logic [7:0] wrap_count
);

  localparam logic [3:0] CNT_MAX   = 4'(STABLE_CYCLES);
  localparam logic [3:0] MAX_VAL   = 4'(MAX_DIGIT);
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_LOCKED = 2'd1,
    S_ERROR  = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] value;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] pat);
    dec_t r;
    r = '{legal: 1'b1, is_blank: 1'b0, value: 4'd0};
    case (pat)
      7'b0000001: r.value = 4'd0;
      7'b1001111: r.value = 4'd1;
      7'b0010010: r.value = 4'd2;
      7'b0000110: r.value = 4'd3;
      7'b1001100: r.value = 4'd4;
      7'b0100100: r.value = 4'd5;
      7'b0100000: r.value = 4'd6;
      7'b0001111: r.value = 4'd7;
      7'b0000000: r.value = 4'd8;
      7'b0000100: r.value = 4'd9;
`ifdef SEG7_HEX_DECODE_EN
      7'b0001000: r.value = 4'd10;
      7'b1100000: r.value = 4'd11;
      7'b0110001: r.value = 4'd12;
      7'b1000010: r.value = 4'd13;
      7'b0110000: r.value = 4'd14;
      7'b0111000: r.value = 4'd15;
`endif
      PAT_BLANK: begin
        r.legal    = 1'b0;
        r.is_blank = 1'b1;
      end
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

  state_t     state_q, state_d;
  logic [6:0] samp_q, samp_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] last_q, last_d;
  logic [3:0] ref_q, ref_d;
  logic [3:0] digit_q, digit_d;
  logic       digit_valid_q, digit_valid_d;
  logic       blank_q, blank_d;
  logic       illegal_q, illegal_d;
  logic       wrap_pulse_q, wrap_pulse_d;
  logic       seq_error_q, seq_error_d;
  logic [7:0] wrap_count_q, wrap_count_d;

  logic       accept;
  dec_t       dec;
  logic [4:0] ref_inc;

  always_ff @(posedge clock or posedge RESET) begin
    if (RESET) begin
      state_q       <= S_EMPTY;
      samp_q        <= PAT_BLANK;
      cnt_q         <= 4'd0;
      last_q        <= PAT_BLANK;
      ref_q         <= 4'd0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      blank_q       <= 1'b1;
      illegal_q     <= 1'b0;
      wrap_pulse_q  <= 1'b0;
      seq_error_q   <= 1'b0;
      wrap_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      samp_q        <= samp_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      ref_q         <= ref_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      blank_q       <= blank_d;
      illegal_q     <= illegal_d;
      wrap_pulse_q  <= wrap_pulse_d;
      seq_error_q   <= seq_error_d;
      wrap_count_q  <= wrap_count_d;
    end
  end

  // The counter holds the number of edges the current sample has survived unchanged,
  // so it reaches STABLE_CYCLES on the (STABLE_CYCLES+1)th edge after an input change.
  always_comb begin
    samp_d = {a, b, c, d, e, f, g};
    if (samp_d != samp_q) begin
      cnt_d = 4'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    accept  = (cnt_d == CNT_MAX) && (samp_q != last_q);
    dec     = decode(samp_q);
    ref_inc = {1'b0, ref_q} + 5'd1;
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    ref_d         = ref_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    blank_d       = blank_q;
    illegal_d     = 1'b0;
    wrap_pulse_d  = 1'b0;
    seq_error_d   = 1'b0;
    wrap_count_d  = wrap_count_q;

    if (accept) begin
      last_d = samp_q;
      if (dec.is_blank) begin
        blank_d = 1'b1;
        state_d = S_EMPTY;
      end else if (!dec.legal) begin
        illegal_d = 1'b1;
        state_d   = S_ERROR;
      end else begin
        digit_d       = dec.value;
        digit_valid_d = 1'b1;
        blank_d       = 1'b0;
        ref_d         = dec.value;
        state_d       = S_LOCKED;
        case (state_q)
          S_LOCKED: begin
            if (({1'b0, dec.value} == ref_inc) && (dec.value <= MAX_VAL)) begin
              seq_error_d = 1'b0;
            end else if ((ref_q == MAX_VAL) && (dec.value == 4'd0)) begin
              wrap_pulse_d = 1'b1;
              wrap_count_d = wrap_count_q + 8'd1;
            end else if (dec.value == 4'd0) begin
              // upstream counter was reset: restart silently
              seq_error_d = 1'b0;
            end else begin
              seq_error_d = 1'b1;
            end
          end
          default: seq_error_d = 1'b0;
        endcase
      end
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign blank       = blank_q;
  assign illegal     = illegal_q;
  assign wrap_pulse  = wrap_pulse_q;
  assign seq_error   = seq_error_q;
  assign wrap_count  = wrap_count_q;

endmodule

// File: tb/tb_seg7_sequence_decoder.sv
// Scoreboard bench for seg7_sequence_decoder (STABLE_CYCLES=2, MAX_DIGIT=5).
// Expected pulse records are queued when a new pattern is driven and matched against DUT pulses.

module tb_seg7_sequence_decoder;

  localparam int STABLE = 2;
  localparam int MAXD   = 5;

  logic       clock = 1'b0;
  logic       RESET = 1'b1;
  logic       a, b, c, d, e, f, g;
  logic [3:0] digit;
  logic       digit_valid, blank, illegal, wrap_pulse, seq_error;
  logic [7:0] wrap_count;

  seg7_sequence_decoder #(.STABLE_CYCLES(STABLE), .MAX_DIGIT(MAXD)) dut (
    .clock(clock), .RESET(RESET),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .digit(digit), .digit_valid(digit_valid), .blank(blank), .illegal(illegal),
    .wrap_pulse(wrap_pulse), .seq_error(seq_error), .wrap_count(wrap_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] digit;
    logic       dv, blank, ill, wrap, seq;
    logic [7:0] wc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en = 1'b0;

  localparam logic [6:0] P_BLANK = 7'b1111111;
  localparam logic [6:0] P_BAD   = 7'b1111000;
  localparam logic [6:0] P_HEXA  = 7'b0001000;
  logic [6:0] pat_tab [10];

  // model state
  logic [6:0] m_last;
  int         m_state;  // 0 empty, 1 locked, 2 error
  int         m_p;
  logic [3:0] m_digit;
  logic       m_blank;
  logic [7:0] m_wc;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int tb_decode(input logic [6:0] pat);
    for (int i = 0; i < 10; i++) if (pat == pat_tab[i]) return i;
    if (pat == P_BLANK) return 16;
`ifdef SEG7_HEX_DECODE_EN
    case (pat)
      7'b0001000: return 10;
      7'b1100000: return 11;
      7'b0110001: return 12;
      7'b1000010: return 13;
      7'b0110000: return 14;
      7'b0111000: return 15;
      default: ;
    endcase
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_last = P_BLANK; m_state = 0; m_p = 0; m_digit = 4'd0; m_blank = 1'b1; m_wc = 8'd0;
  endtask

  // Drive a pattern at a negedge; if it is a new pattern, predict the result.
  task automatic drive_pat(input logic [6:0] pat, input int hold);
    exp_t x;
    int   v;
    if (pat != m_last) begin
      m_last = pat;
      v = tb_decode(pat);
      x.cyc = cyc + STABLE + 1;
      x.dv = 0; x.ill = 0; x.wrap = 0; x.seq = 0;
      if (v == 16) begin
        m_blank = 1'b1; m_state = 0;
      end else if (v < 0) begin
        m_state = 2;
        x.ill = 1; x.digit = m_digit; x.blank = m_blank; x.wc = m_wc;
        q.push_back(x);
      end else begin
        if (m_state == 1) begin
          if (v == m_p + 1 && v <= MAXD) ;
          else if (m_p == MAXD && v == 0) begin x.wrap = 1; m_wc = m_wc + 8'd1; end
          else if (v == 0) ;
          else x.seq = 1;
        end
        m_digit = 4'(v); m_blank = 1'b0; m_p = v; m_state = 1;
        x.dv = 1; x.digit = m_digit; x.blank = 1'b0; x.wc = m_wc;
        q.push_back(x);
      end
    end
    {a, b, c, d, e, f, g} = pat;
    repeat (hold) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      exp_t x;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check_val("missed_pulse_cycle", 32'(cyc), 32'(q[0].cyc));
        void'(q.pop_front());
      end
      if (digit_valid | illegal | wrap_pulse | seq_error) begin
        if (q.size() == 0) begin
          check_val("unexpected_pulse", {28'd0, digit_valid, illegal, wrap_pulse, seq_error}, 32'd0);
        end else begin
          x = q.pop_front();
          check_val("pulse_cycle", 32'(cyc), 32'(x.cyc));
          check_val("digit", 32'(digit), 32'(x.digit));
          check_val("digit_valid", 32'(digit_valid), 32'(x.dv));
          check_val("illegal", 32'(illegal), 32'(x.ill));
          check_val("wrap_pulse", 32'(wrap_pulse), 32'(x.wrap));
          check_val("seq_error", 32'(seq_error), 32'(x.seq));
          check_val("blank_at_pulse", 32'(blank), 32'(x.blank));
          check_val("wrap_count", 32'(wrap_count), 32'(x.wc));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string pfx);
    check_val({pfx, "_digit"}, 32'(digit), 32'd0);
    check_val({pfx, "_digit_valid"}, 32'(digit_valid), 32'd0);
    check_val({pfx, "_blank"}, 32'(blank), 32'd1);
    check_val({pfx, "_illegal"}, 32'(illegal), 32'd0);
    check_val({pfx, "_wrap_pulse"}, 32'(wrap_pulse), 32'd0);
    check_val({pfx, "_seq_error"}, 32'(seq_error), 32'd0);
    check_val({pfx, "_wrap_count"}, 32'(wrap_count), 32'd0);
  endtask

  initial begin
    logic [7:0] wc_snap;
    pat_tab[0] = 7'b0000001; pat_tab[1] = 7'b1001111; pat_tab[2] = 7'b0010010;
    pat_tab[3] = 7'b0000110; pat_tab[4] = 7'b1001100; pat_tab[5] = 7'b0100100;
    pat_tab[6] = 7'b0100000; pat_tab[7] = 7'b0001111; pat_tab[8] = 7'b0000000;
    pat_tab[9] = 7'b0000100;
    {a, b, c, d, e, f, g} = P_BLANK;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    RESET = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clock);

    // 0..5 then wrap to 0
    for (int i = 0; i <= MAXD; i++) drive_pat(pat_tab[i], 4);
    drive_pat(pat_tab[0], 4);

    // climb to 3, then a one-cycle glitch must not register
    for (int i = 1; i <= 3; i++) drive_pat(pat_tab[i], 4);
    {a, b, c, d, e, f, g} = P_BAD;
    @(negedge clock);
    {a, b, c, d, e, f, g} = pat_tab[3];
    repeat (5) @(negedge clock);
    check_val("glitch_digit_holds", 32'(digit), 32'd3);

    // restart, skip 3 -> seq_error, then clean 5 and wrap
    drive_pat(pat_tab[0], 4);
    drive_pat(pat_tab[1], 4);
    drive_pat(pat_tab[2], 4);
    drive_pat(pat_tab[4], 4);
    drive_pat(pat_tab[5], 4);
    drive_pat(pat_tab[0], 4);

    // illegal, then unchecked 3, then clean 4
    drive_pat(P_BAD, 4);
    drive_pat(pat_tab[3], 4);
    drive_pat(pat_tab[4], 4);

    // blank then 2: blank level and no sequence check
    drive_pat(P_BLANK, 4);
    check_val("blank_level_set", 32'(blank), 32'd1);
    check_val("blank_digit_holds", 32'(digit), 32'd4);
    drive_pat(pat_tab[2], 4);
    check_val("blank_level_clear", 32'(blank), 32'd0);

    // digit above MAX_DIGIT, then hex A pattern
    drive_pat(pat_tab[9], 4);
    drive_pat(P_HEXA, 4);

    // 256 full cycles bring wrap_count back around
    drive_pat(P_BLANK, 4);
    drive_pat(pat_tab[0], 4);
    wc_snap = m_wc;
    for (int k = 0; k < 256; k++) begin
      for (int i = 1; i <= MAXD; i++) drive_pat(pat_tab[i], 4);
      drive_pat(pat_tab[0], 4);
    end
    check_val("wrap_count_256_model", 32'(wrap_count), 32'(m_wc));
    check_val("wrap_count_256_returns", 32'(wrap_count), 32'(wc_snap));

    // async reset mid-digit
    drive_pat(pat_tab[3], 4);
    {a, b, c, d, e, f, g} = pat_tab[1];
    @(negedge clock);
    @(posedge clock);
    #2;
    RESET = 1'b1;
    mon_en = 1'b0;
    q.delete();
    #1;
    check_reset_outputs("async_reset");
    {a, b, c, d, e, f, g} = P_BLANK;
    model_reset();
    repeat (3) @(negedge clock);
    RESET = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clock);
    drive_pat(pat_tab[3], 4);
    drive_pat(pat_tab[4], 4);

    repeat (4) @(negedge clock);
    check_val("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
